// File: rtl/baud_pkg.sv
// Shared baud-rate helpers and receiver state encoding for the UART blocks.
package baud_pkg;

  localparam int unsigned ovsamp_rate = 8;
  localparam integer      START_TICKS = ovsamp_rate / 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  // Clocks per oversample tick; callers must reject CLK_RATE <= ovsamp_rate*BAUD_RATE.
  function automatic int unsigned bddiv(input int unsigned clk_rate,
                                        input int unsigned baud_rate);
    return clk_rate / (baud_rate * ovsamp_rate);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on the last count.
module uart_baud_tick #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] bcnt;

  assign tick = en && (bcnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= '0;
    end else if (!en || tick) begin
      bcnt <= '0;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ovsamp.sv
// 8N1 UART receiver with 8x oversampling and a ready/valid byte output.
module uart_rx_ovsamp
  import baud_pkg::*;
#(
  parameter int unsigned CLK_RATE  = 100_000_000,
  parameter int unsigned BAUD_RATE = 3_000_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned BDDIV = bddiv(CLK_RATE, BAUD_RATE);
  localparam logic [2:0]  OLAST = 3'(ovsamp_rate - 1);
  localparam logic [2:0]  SLAST = 3'(START_TICKS - 1);

  if (CLK_RATE <= ovsamp_rate * BAUD_RATE) begin : g_rate_check
    $fatal(1, "uart_rx_ovsamp: CLK_RATE must exceed 8*BAUD_RATE");
  end

  logic      rx_meta;
  logic      rx_s;
  rx_state_e state;
  logic [2:0] ocnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic       tick;
  logic       done_good;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  uart_baud_tick #(.DIV(BDDIV)) u_tick (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (state != IDLE),
    .tick  (tick)
  );

  assign done_good = (state == STOP) && tick && (ocnt == OLAST) && rx_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      ocnt        <= '0;
      idx         <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          ocnt <= '0;
          idx  <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (tick) begin
            if (ocnt == SLAST) begin
              ocnt  <= '0;
              idx   <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              ocnt <= ocnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            ocnt <= ocnt + 1'b1;
            if (ocnt == OLAST) begin
              shreg[idx] <= rx_s;
              idx        <= idx + 1'b1;
              if (idx == 3'd7) state <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            ocnt <= ocnt + 1'b1;
            if (ocnt == OLAST) begin
              state <= IDLE;
              if (!rx_s) frame_err_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A completion with the held byte not yet taken drops the new byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (done_good) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o  <= shreg;
          rx_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ovsamp.sv
// Directed bench for uart_rx_ovsamp at 16 clocks per bit (BDDIV=2).
module tb_uart_rx_ovsamp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;

  uart_rx_ovsamp #(
    .CLK_RATE  (1_600_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_i        (rx),
    .rx_data_o   (data),
    .rx_valid_o  (valid),
    .rx_ready_i  (ready),
    .frame_err_o (ferr),
    .overrun_o   (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         n_valid = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  int         rise_cyc = 0;
  logic [7:0] cap = '0;
  logic       prev_v = 1'b0;

  always @(negedge clk) begin
    if (valid && !prev_v) begin
      n_valid++;
      cap = data;
      rise_cyc = cyc;
    end
    if (ferr) n_ferr++;
    if (ovr) n_ovr++;
    prev_v = valid;
  end

  int vecs = 0;
  int errs = 0;
  int fall_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick_n(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    fall_cyc = cyc;
    tick_n(16);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         glitch;
    int         exp_v;
    logic [7:0] exp_d;
    int         exp_f;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bv, bf, bo, lat;

    tbl[0] = '{8'hA5, 1'b1, 0, 1, 8'hA5, 0};
    tbl[1] = '{8'h00, 1'b1, 6, 0, 8'h00, 0};
    tbl[2] = '{8'h3C, 1'b1, 0, 1, 8'h3C, 0};
    tbl[3] = '{8'h55, 1'b0, 0, 0, 8'h00, 1};
    tbl[4] = '{8'h0F, 1'b1, 0, 1, 8'h0F, 0};

    for (int i = 0; i < 6; i++) begin
      rx = i[0];
      tick_n(1);
      check("reset_outputs", {data, valid, ferr, ovr}, 0);
    end
    rx = 1'b1;
    rst_n = 1'b1;
    tick_n(20);
    check("post_reset_idle", {data, valid, ferr, ovr}, 0);

    for (int v = 0; v < 5; v++) begin
      bv = n_valid;
      bf = n_ferr;
      bo = n_ovr;
      if (tbl[v].glitch > 0) begin
        rx = 1'b0;
        tick_n(tbl[v].glitch);
        rx = 1'b1;
        tick_n(40);
      end else begin
        send_frame(tbl[v].d, tbl[v].stop);
        rx = 1'b1;
        tick_n(20);
      end
      check($sformatf("vec%0d_valid_count", v), n_valid - bv, tbl[v].exp_v);
      check($sformatf("vec%0d_ferr_count", v), n_ferr - bf, tbl[v].exp_f);
      check($sformatf("vec%0d_ovr_count", v), n_ovr - bo, 0);
      check($sformatf("vec%0d_valid_idle", v), int'(valid), 0);
      if (tbl[v].exp_v == 1) begin
        lat = rise_cyc - fall_cyc;
        check($sformatf("vec%0d_data", v), int'(cap), int'(tbl[v].exp_d));
        check($sformatf("vec%0d_latency_in_152_156(lat=%0d)", v, lat),
              int'(lat >= 152 && lat <= 156), 1);
      end
    end

    ready = 1'b0;
    bv = n_valid;
    bf = n_ferr;
    bo = n_ovr;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rx = 1'b1;
    tick_n(20);
    check("ovr_valid_held", int'(valid), 1);
    check("ovr_data_held", int'(data), 8'h11);
    check("ovr_pulse_count", n_ovr - bo, 1);
    check("ovr_valid_rises", n_valid - bv, 1);
    check("ovr_ferr_count", n_ferr - bf, 0);
    ready = 1'b1;
    tick_n(1);
    check("ovr_consumed_valid", int'(valid), 0);
    check("ovr_consumed_data", int'(data), 8'h11);

    bv = n_valid;
    rx = 1'b0;
    tick_n(16);
    rx = 1'b1;
    tick_n(48 + 8);
    rst_n = 1'b0;
    tick_n(1);
    check("midreset_outputs", {data, valid, ferr, ovr}, 0);
    rst_n = 1'b1;
    tick_n(16 * 5 + 20);
    check("midreset_no_valid", n_valid - bv, 0);
    send_frame(8'h81, 1'b1);
    rx = 1'b1;
    tick_n(20);
    check("after_reset_valid_count", n_valid - bv, 1);
    check("after_reset_data", int'(cap), 8'h81);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
